// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues lw/sw to a req/ack data memory, stalls upstream
// until the ack, and registers the M/W instruction/result; a wait counter aborts hung requests.
module mem_stage_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       ir_in,
  input  logic [31:0]       o_in,
  input  logic [31:0]       b_in,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              stall,
  output logic [31:0]       ir_out,
  output logic [31:0]       o_out,
  output logic              err
);
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       is_lw, is_sw, mem_op, abort;

  assign is_lw  = (ir_in[31:27] == OP_LW);
  assign is_sw  = (ir_in[31:27] == OP_SW);
  assign mem_op = is_lw | is_sw;

  // Ack on the last allowed cycle beats the abort.
  assign abort     = (state == WAIT) && (cnt == CNT_LAST) && !mem_ack;
  assign mem_req   = mem_op;
  assign mem_we    = is_sw;
  assign mem_addr  = o_in[ADDR_W-1:0];
  assign mem_wdata = b_in;
  assign stall     = mem_req & ~mem_ack & ~abort;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (mem_op && !mem_ack) begin
          state_nx = WAIT;
          cnt_nx   = 8'd1;
        end
      end
      WAIT: begin
        // A vanished mem_op cannot happen with a well-behaved upstream; recover anyway.
        if (!mem_op || mem_ack || abort) begin
          state_nx = IDLE;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_out <= 32'd0;
      o_out  <= 32'd0;
      err    <= 1'b0;
    end else begin
      err <= err | abort;
      if (stall || abort) begin
        ir_out <= 32'd0;
        o_out  <= 32'd0;
      end else begin
        ir_out <= ir_in;
        o_out  <= is_lw ? mem_rdata : o_in;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed + randomized bench for mem_stage_ctrl; each instruction is checked
// against a transaction-level model (ack latency -> stall count, result, err).
module tb_mem_stage_ctrl;
  localparam int ADDR_W = 12;
  localparam int T      = 16;
  localparam logic [4:0] OP_SW = 5'b00111;
  localparam logic [4:0] OP_LW = 5'b01000;

  logic              clock = 1'b0;
  logic              reset;
  logic [31:0]       ir_in, o_in, b_in, mem_rdata;
  logic              mem_ack;
  logic              mem_req, mem_we, stall, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, ir_out, o_out;

  int checks = 0;
  int errors = 0;
  logic err_exp = 1'b0;

  mem_stage_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(T)) dut (
    .clock(clock), .reset(reset), .ir_in(ir_in), .o_in(o_in), .b_in(b_in),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall), .ir_out(ir_out),
    .o_out(o_out), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op);
    mk = {op, 27'($urandom)};
  endfunction

  // Runs one instruction whose ack would arrive in cycle k after issue.
  // Model: k<=T-1 completes in cycle k after k stalled cycles; k>T-1 aborts in cycle T-1.
  task automatic run_instr(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] b,
                           input logic [31:0] rd, input int k);
    logic is_mem, is_lw, aborted, last;
    int keff;
    is_lw   = (ir[31:27] == OP_LW);
    is_mem  = is_lw || (ir[31:27] == OP_SW);
    aborted = is_mem && (k > T - 1);
    keff    = !is_mem ? 0 : (aborted ? T - 1 : k);
    for (int c = 0; c <= keff; c++) begin
      last      = (c == keff);
      ir_in     = ir;
      o_in      = o;
      b_in      = b;
      mem_ack   = is_mem ? (c == k) : 1'($urandom);
      mem_rdata = (is_mem && c == k) ? rd : $urandom;
      #1;
      chk("mem_req", 32'(mem_req), 32'(is_mem));
      chk("stall", 32'(stall), 32'(is_mem && !last));
      if (is_mem) begin
        chk("mem_we", 32'(mem_we), 32'(!is_lw));
        chk("mem_addr", 32'(mem_addr), {20'd0, o[ADDR_W-1:0]});
        chk("mem_wdata", mem_wdata, b);
      end
      @(posedge clock); #1;
      if (!last || aborted) begin
        chk("ir_out_bubble", ir_out, 32'd0);
        chk("o_out_bubble", o_out, 32'd0);
      end else begin
        chk("ir_out", ir_out, ir);
        chk("o_out", o_out, is_lw ? rd : o);
      end
      if (last && aborted) err_exp = 1'b1;
      chk("err", 32'(err), 32'(err_exp));
    end
  endtask

  initial begin
    logic [31:0] lw_i, rd;
    logic [4:0]  op;
    int k;
    reset = 1'b1; ir_in = '0; o_in = '0; b_in = '0; mem_rdata = '0; mem_ack = 1'b0;
    #1;
    chk("rst_ir_out", ir_out, 32'd0);
    chk("rst_o_out", o_out, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // Directed scenarios
    run_instr({5'b00000, 27'h123}, 32'h1234, 32'h0, 32'h0, 0);
    run_instr(mk(OP_LW), 32'h0000_0ABC, 32'h0, 32'hDEAD_BEEF, 0);
    run_instr(mk(OP_SW), 32'h0000_0010, 32'h5555_AAAA, 32'h0, 3);
    run_instr(mk(OP_LW), 32'h0000_0FFF, 32'h0, 32'h1111_2222, T - 1);
    run_instr(mk(OP_LW), 32'h0000_0020, 32'h0, 32'h0, 1000);
    run_instr(mk(OP_LW), 32'h0000_0030, 32'h0, 32'hCAFE_0001, 1);
    run_instr(mk(OP_SW), 32'h0000_0040, 32'h7777_8888, 32'h0, 1);
    run_instr({5'b11111, 27'h5}, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);

    // Reset during WAIT after 5 stalled cycles
    lw_i = mk(OP_LW);
    ir_in = lw_i; o_in = 32'h0000_0055; b_in = 32'h0; mem_ack = 1'b0;
    for (int c = 0; c < 5; c++) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    err_exp = 1'b0;
    chk("wrst_ir_out", ir_out, 32'd0);
    chk("wrst_o_out", o_out, 32'd0);
    chk("wrst_err", 32'(err), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    // Full T-1 stalls before abort proves the counter restarted.
    run_instr(lw_i, 32'h0000_0055, 32'h0, 32'h0, T + 3);
    run_instr(lw_i, 32'h0000_0055, 32'h0, 32'hABCD_0123, 2);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: op = OP_LW;
        1: op = OP_SW;
        default: begin
          op = 5'($urandom);
          if (op == OP_LW || op == OP_SW) op = 5'b00001;
        end
      endcase
      k  = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 4);
      rd = $urandom;
      run_instr(mk(op), $urandom, $urandom, rd, k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
